// File: rtl/ps2_key_decoder.sv
// PS/2 host-receive front end for Pong: frames device bytes, decodes make/break
// scan codes into held paddle controls, a start pulse and per-byte status pulses.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  KEY_LEFT_UP    = 8'h1D,
  parameter logic [7:0]  KEY_LEFT_DOWN  = 8'h1B,
  parameter logic [7:0]  KEY_RIGHT_UP   = 8'h75,
  parameter logic [7:0]  KEY_RIGHT_DOWN = 8'h72,
  parameter logic [7:0]  KEY_START      = 8'h29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       move_left_up,
  output logic       move_left_down,
  output logic       move_right_up,
  output logic       move_right_down,
  output logic       start_pulse,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_error
);

  localparam int unsigned    TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic          clk_meta_q, clk_sync_q, clk_prev_q, dat_meta_q, dat_sync_q;
  logic          fall_q, fall_d, bit_q, bit_d;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  // held flags: [0] left up, [1] left down, [2] right up, [3] right down
  logic [3:0]    held_q, held_d;
  logic [3:0]    move_q, move_d;
  logic          start_q, start_d, valid_q, valid_d, error_q, error_d;
  logic [7:0]    code_q, code_d;
  logic          byte_done_s, frame_bad_s;

  always_comb begin
    fall_d      = clk_prev_q & ~clk_sync_q;
    bit_d       = dat_sync_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    held_d      = held_q;
    code_d      = code_q;
    start_d     = 1'b0;
    valid_d     = 1'b0;
    error_d     = 1'b0;
    byte_done_s = 1'b0;
    frame_bad_s = 1'b0;

    if (fall_q) begin
      tmo_d = '0;
    end else if (state_q != ST_IDLE) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = '0;
    end

    if (fall_q) begin
      case (state_q)
        ST_IDLE: begin
          if (!bit_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d   = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_d   = {bit_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PARITY: begin
          parity_d = bit_q;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (bit_q && odd_parity_ok(shift_q, parity_q)) begin
            byte_done_s = 1'b1;
          end else begin
            frame_bad_s = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && (tmo_q == TMO_MAX)) begin
      state_d     = ST_IDLE;
      frame_bad_s = 1'b1;
    end else begin
      state_d = state_q;
    end

    // Prefix bytes only arm flags; a key byte consumes them whether or not it matches.
    if (byte_done_s) begin
      valid_d = 1'b1;
      code_d  = shift_q;
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (shift_q == KEY_LEFT_UP && !ext_q) begin
          held_d[0] = ~brk_q;
        end else if (shift_q == KEY_LEFT_DOWN && !ext_q) begin
          held_d[1] = ~brk_q;
        end else if (shift_q == KEY_RIGHT_UP && ext_q) begin
          held_d[2] = ~brk_q;
        end else if (shift_q == KEY_RIGHT_DOWN && ext_q) begin
          held_d[3] = ~brk_q;
        end else if (shift_q == KEY_START && !ext_q) begin
          start_d = ~brk_q;
        end else begin
          held_d = held_q;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end else if (frame_bad_s) begin
      error_d = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end else begin
      valid_d = 1'b0;
    end

    move_d[0] = held_d[0] & ~held_d[1];
    move_d[1] = held_d[1] & ~held_d[0];
    move_d[2] = held_d[2] & ~held_d[3];
    move_d[3] = held_d[3] & ~held_d[2];
  end

  // State update: synchronizers idle high on reset, everything else clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      fall_q     <= 1'b0;
      bit_q      <= 1'b0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      held_q     <= 4'd0;
      move_q     <= 4'd0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      code_q     <= 8'd0;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat;
      dat_sync_q <= dat_meta_q;
      fall_q     <= fall_d;
      bit_q      <= bit_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      held_q     <= held_d;
      move_q     <= move_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      code_q     <= code_d;
    end
  end

  assign move_left_up    = move_q[0];
  assign move_left_down  = move_q[1];
  assign move_right_up   = move_q[2];
  assign move_right_down = move_q[3];
  assign start_pulse     = start_q;
  assign scan_valid      = valid_q;
  assign scan_code       = code_q;
  assign frame_error     = error_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Drives PS/2 frames (directed then random) and checks the decoder against a
// key-state model of make/break/prefix rules.
module tb_ps2_key_decoder;

  localparam int T = 50000;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       move_left_up, move_left_down, move_right_up, move_right_down;
  logic       start_pulse, scan_valid, frame_error;
  logic [7:0] scan_code;

  ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .move_left_up(move_left_up), .move_left_down(move_left_down),
    .move_right_up(move_right_up), .move_right_down(move_right_down),
    .start_pulse(start_pulse), .scan_valid(scan_valid),
    .scan_code(scan_code), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: key states by name, prefixes, last good byte
  bit m_ext, m_brk, m_w, m_s, m_up, m_dn;
  logic [7:0] m_code;

  int rel, n_sv, n_fe, n_sp, sv_k, fe_k, sp_k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rel++;
      if (scan_valid === 1'b1) begin n_sv++; sv_k = rel; end
      if (frame_error === 1'b1) begin n_fe++; fe_k = rel; end
      if (start_pulse === 1'b1) begin n_sp++; sp_k = rel; end
    end
  endtask

  function automatic void model_byte(input logic [7:0] b, output bit sp);
    sp = 1'b0;
    m_code = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (!m_ext && b == 8'h1D) m_w = !m_brk;
      if (!m_ext && b == 8'h1B) m_s = !m_brk;
      if (m_ext && b == 8'h75) m_up = !m_brk;
      if (m_ext && b == 8'h72) m_dn = !m_brk;
      if (!m_ext && !m_brk && b == 8'h29) sp = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  task automatic check_moves(input string tag);
    check({tag, ".lu"}, 32'(move_left_up),    (in_reset_now() ? 32'd0 : 32'(m_w && !m_s)));
    check({tag, ".ld"}, 32'(move_left_down),  (in_reset_now() ? 32'd0 : 32'(m_s && !m_w)));
    check({tag, ".ru"}, 32'(move_right_up),   (in_reset_now() ? 32'd0 : 32'(m_up && !m_dn)));
    check({tag, ".rd"}, 32'(move_right_down), (in_reset_now() ? 32'd0 : 32'(m_dn && !m_up)));
  endtask

  function automatic bit in_reset_now();
    return reset;
  endfunction

  // bad: 0 good, 1 even parity, 2 stop bit low
  task automatic send(input logic [7:0] b, input int bad, input string tag);
    logic [10:0] bits;
    bit good, sp;
    bits[0] = 1'b0;
    bits[8:1] = b;
    bits[9] = ~(^b) ^ (bad == 1);
    bits[10] = (bad != 2);
    n_sv = 0; n_fe = 0; n_sp = 0; sv_k = 0; fe_k = 0; sp_k = 0; rel = -1000;
    for (int i = 0; i < 11; i++) begin
      ps2_dat = bits[i];
      ticks(H);
      ps2_clk = 1'b0;
      if (i == 10) rel = 0;
      ticks(H);
      ps2_clk = 1'b1;
    end
    ticks(H);
    good = (bad == 0) && !reset;
    sp = 1'b0;
    if (reset) begin
      m_ext = 0; m_brk = 0; m_w = 0; m_s = 0; m_up = 0; m_dn = 0; m_code = 8'd0;
    end else if (good) begin
      model_byte(b, sp);
    end else begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    check({tag, ".sv_n"},  32'(n_sv), good ? 32'd1 : 32'd0);
    check({tag, ".sv_at"}, 32'(sv_k), good ? 32'd4 : 32'd0);
    check({tag, ".fe_n"},  32'(n_fe), (!good && !reset) ? 32'd1 : 32'd0);
    check({tag, ".fe_at"}, 32'(fe_k), (!good && !reset) ? 32'd4 : 32'd0);
    check({tag, ".sp_n"},  32'(n_sp), sp ? 32'd1 : 32'd0);
    check({tag, ".sp_at"}, 32'(sp_k), sp ? 32'd4 : 32'd0);
    check({tag, ".code"},  32'(scan_code), 32'(m_code));
    check_moves(tag);
  endtask

  initial begin
    logic [7:0] pool [8];
    logic [7:0] b;
    int bad;
    pool[0] = 8'h1D; pool[1] = 8'h1B; pool[2] = 8'h75; pool[3] = 8'h72;
    pool[4] = 8'h29; pool[5] = 8'hE0; pool[6] = 8'hF0; pool[7] = 8'h00;
    m_ext = 0; m_brk = 0; m_w = 0; m_s = 0; m_up = 0; m_dn = 0; m_code = 8'd0;

    repeat (3) @(negedge clk);
    send(8'h1D, 0, "rst_frame");
    check("rst.valid", 32'(scan_valid), 32'd0);
    reset = 1'b0;
    ticks(2);
    send(8'h1D, 0, "w_make");

    send(8'hF0, 0, "w_brk0");  send(8'h1D, 0, "w_brk1");
    send(8'hE0, 0, "up_mk0");  send(8'h75, 0, "up_mk1");
    send(8'hE0, 0, "up_bk0");  send(8'hF0, 0, "up_bk1");  send(8'h75, 0, "up_bk2");
    send(8'h75, 0, "bare75");

    send(8'h1D, 0, "opp_w");   send(8'h1B, 0, "opp_s");
    send(8'hF0, 0, "opp_r0");  send(8'h1B, 0, "opp_r1");
    send(8'hF0, 0, "clr0");    send(8'h1D, 0, "clr1");

    send(8'h1D, 1, "par_err");
    send(8'h1D, 2, "stop_err");

    // partial frame: start bit plus 4 data bits, then the clock stalls
    n_fe = 0; fe_k = 0; n_sv = 0; n_sp = 0; rel = -1000;
    for (int i = 0; i < 5; i++) begin
      ps2_dat = (i == 0) ? 1'b0 : 1'b1;
      ticks(H);
      ps2_clk = 1'b0;
      if (i == 4) rel = 0;
      ticks(H);
      ps2_clk = 1'b1;
    end
    while (n_fe == 0 && rel < T + 100) ticks(1);
    m_ext = 1'b0; m_brk = 1'b0;
    check("tmo.fe_n", 32'(n_fe), 32'd1);
    check("tmo.late", 32'((fe_k >= T) && (fe_k <= T + 10)), 32'd1);
    check("tmo.sv_n", 32'(n_sv), 32'd0);
    send(8'h1B, 0, "tmo_next");
    send(8'hF0, 0, "tmo_c0");  send(8'h1B, 0, "tmo_c1");

    send(8'h29, 0, "start1");  send(8'h29, 0, "start2");
    send(8'hF0, 0, "start_b0"); send(8'h29, 0, "start_b1");

    send(8'hE0, 0, "pre_e0");  send(8'h75, 1, "pre_bad");  send(8'h75, 0, "pre_75");

    for (int n = 0; n < 60; n++) begin
      b = pool[$urandom_range(0, 7)];
      if (b == 8'h00) b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      send(b, bad, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
